mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store sequencer between the multi-cycle control unit and the byte-addressed, big-endian data memory.
//  Turns byte/halfword/word requests into word-aligned memory cycles.
//  Sub-word stores use read-modify-write. Loads return an extracted, sign- or zero-extended result.
// PARAMETERS
//  ADDR_W     32  byte-address width, CPU and memory side
//  READ_WAIT   0  extra cycles held in READ before mem_rdata is captured (0..15)
// PORTS
//  CLK        in   1       clock; all state updates on posedge
//  Reset      in   1       synchronous, active-low reset
//  req        in   1       start access; sampled only in IDLE
//  we         in   1       1 = store, 0 = load
//  size       in   2       00 byte, 01 half, 10 word, 11 treated as word
//  sign_ext   in   1       loads: 1 sign-extend, 0 zero-extend
//  addr       in   ADDR_W  byte address
//  wdata      in   32      store data, right-justified for byte/half
//  busy       out  1       high from accept edge until the cycle after done
//  done       out  1       1-cycle pulse; rdata/misalign valid in that cycle
//  rdata      out  32      load result; holds until the next done
//  misalign   out  1       misaligned request flag, valid with done
//  mem_addr   out  ADDR_W  {addr[ADDR_W-1:2],2'b00}, registered
//  mem_wdata  out  32      merged write word, registered
//  mem_rd     out  1       high while in READ
//  mem_wr_n   out  1       active-low write strobe; low exactly one cycle (WRITE)
//  mem_rdata  in   32      combinational read data from memory
// BEHAVIOUR
//  Reset values: busy 0, done 0, rdata 0, misalign 0, mem_rd 0, mem_wr_n 1, mem_addr 0, mem_wdata 0.
//  States: IDLE, READ, WRITE, DONE. Request fields are latched at the accept edge.
//  IDLE + req:
//    load                -> READ
//    word store          -> WRITE
//    byte/half store     -> READ
//  READ: mem_rd=1; waits READ_WAIT cycles on a counter; captures mem_rdata on the final edge.
//    load  -> DONE
//    store -> WRITE
//  WRITE: mem_wr_n=0, mem_wdata = merged word -> DONE. Memory commits on the following negedge.
//  DONE: done=1, busy=1 -> IDLE. req is ignored in READ/WRITE/DONE; no queuing.
//  Latency (accept edge = 0, READ_WAIT=0): load done at edge 2; word store at 2; sub-word store at 3.
//  Byte lanes, big-endian. Offset o = addr[1:0].
//    byte: lane bits [31-8o -: 8]
//    half: o=0 -> [31:16], o=2 -> [15:0]
//  Store merge replaces only the addressed lane(s) of the captured word with the low bits of wdata.
//  Load extracts the lane(s) and extends to 32 bits per sign_ext; word loads pass through unchanged.
//  Reset mid-operation: FSM -> IDLE at the sampling edge, mem_wr_n=1 from that edge.
//    A WRITE cycle already driven before that edge still commits at its negedge.
//    No done pulse for the aborted request.
// CONFIGURATION
//  MAU_ALIGN_CHECK_EN defined:
//    half with addr[0]=1, or word with addr[1:0]!=0 -> no memory cycle; IDLE -> DONE
//    done=1, misalign=1, rdata=0; memory untouched.
//  Undefined:
//    misalign tied 0
//    half ignores addr[0]; word ignores addr[1:0]; access proceeds normally.
// STRUCTURE
//  mau_pkg:
//    size encodings SZ_BYTE/SZ_HALF/SZ_WORD
//    state enum
//    lane-extract / merge function prototypes
//  Sub-module mau_lane_merge (combinational):
//    in:  word, wdata, size, offset, sign_ext
//    out: merged store word, extended load result
//  The FSM, wait counter and registers stay in mem_access_unit.
// TESTING
//  Word store 0x11223344 @0x10, then word load @0x10 -> mem_wr_n low 1 cycle; done at edge 2; rdata=0x11223344.
//  Byte store 0xAB @0x12 over 0x11223344 -> READ then WRITE; memory word 0x1122AB44; done at edge 3.
//  Byte load @0x12, sign_ext=1 -> rdata=0xFFFFFFAB; sign_ext=0 -> 0x000000AB.
//  Half load @0x10 over 0x8001xxxx, sign_ext=1 -> 0xFFFF8001; half store 0xBEEF @0x12 -> word 0x1122BEEF.
//  Reset low during READ of a sub-word store -> IDLE next edge; mem_wr_n stays 1; no done; memory unchanged.
//  Word load @0x11:
//    MAU_ALIGN_CHECK_EN -> done at edge 1, misalign=1, mem_rd never high
//    otherwise -> reads word @0x10

Source files
------------

// File: rtl/mau_pkg.sv
// Shared types and lane helpers for the load/store sequencer.
// Big-endian byte lanes: byte offset 0 lives in bits [31:24].
package mau_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} mauState_e;

   // Replace the addressed lane(s) of word with the low bits of wdata.
   function automatic logic [31:0] laneMerge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  offset);
      logic [31:0] r;
      r = word;
      case (size)
         SZ_BYTE: begin
            unique case (offset)
               2'd0: r[31:24] = wdata[7:0];
               2'd1: r[23:16] = wdata[7:0];
               2'd2: r[15:8]  = wdata[7:0];
               2'd3: r[7:0]   = wdata[7:0];
            endcase
         end
         // offset[0] is ignored for halves
         SZ_HALF: begin
            if (offset[1]) r[15:0]  = wdata[15:0];
            else           r[31:16] = wdata[15:0];
         end
         default: r = wdata;
      endcase
      return r;
   endfunction

   // Pull the addressed lane(s) out of word and extend to 32 bits.
   function automatic logic [31:0] laneExtract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  offset,
                                               input logic        signExt);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      unique case (offset)
         2'd0: b = word[31:24];
         2'd1: b = word[23:16];
         2'd2: b = word[15:8];
         2'd3: b = word[7:0];
      endcase
      h = offset[1] ? word[15:0] : word[31:16];
      case (size)
         SZ_BYTE: r = {{24{signExt & b[7]}}, b};
         SZ_HALF: r = {{16{signExt & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mau_lane_merge.sv
// Combinational lane logic: store-merge word and extended load result.
module mau_lane_merge
   import mau_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        sign_ext,
   output logic [31:0] merged,
   output logic [31:0] extended
);

   // Both results are pure functions of the captured memory word.
   always_comb begin
      merged   = laneMerge(word, wdata, size, offset);
      extended = laneExtract(word, size, offset, sign_ext);
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: turns byte/half/word requests into word-aligned
// memory cycles; sub-word stores use read-modify-write.
// Optional feature macro: MAU_ALIGN_CHECK_EN (misaligned half/word requests
// complete immediately with misalign=1 and no memory cycle).
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned READ_WAIT = 0
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic [31:0]       rdata,
   output logic              misalign,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr_n,
   input  logic [31:0]       mem_rdata
);

   localparam logic [3:0] WaitLast = 4'(READ_WAIT);

   mauState_e   state;
   logic [3:0]  waitCnt;
   logic        weQ;
   logic [1:0]  sizeQ;
   logic [1:0]  offsetQ;
   logic        signExtQ;
   logic [31:0] wdataQ;
   logic [31:0] mergedWord;
   logic [31:0] loadWord;
   logic        reqMisaligned;

`ifdef MAU_ALIGN_CHECK_EN
   assign reqMisaligned = ((size == SZ_HALF) && addr[0]) ||
                          (size[1] && (addr[1:0] != 2'b00));
`else
   assign reqMisaligned = 1'b0;
`endif

   mau_lane_merge u_lane_merge (
      .word     (mem_rdata),
      .wdata    (wdataQ),
      .size     (sizeQ),
      .offset   (offsetQ),
      .sign_ext (signExtQ),
      .merged   (mergedWord),
      .extended (loadWord)
   );

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state     <= StIdle;
         waitCnt   <= 4'd0;
         weQ       <= 1'b0;
         sizeQ     <= SZ_BYTE;
         offsetQ   <= 2'b00;
         signExtQ  <= 1'b0;
         wdataQ    <= 32'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rdata     <= 32'd0;
         misalign  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 32'd0;
         mem_rd    <= 1'b0;
         mem_wr_n  <= 1'b1;
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (req) begin
                  busy     <= 1'b1;
                  weQ      <= we;
                  sizeQ    <= size;
                  offsetQ  <= addr[1:0];
                  signExtQ <= sign_ext;
                  wdataQ   <= wdata;
                  if (reqMisaligned) begin
                     // Complete at once; memory is never touched.
                     misalign <= 1'b1;
                     rdata    <= 32'd0;
                     done     <= 1'b1;
                     state    <= StDone;
                  end else begin
                     misalign <= 1'b0;
                     mem_addr <= {addr[ADDR_W-1:2], 2'b00};
                     if (we && size[1]) begin
                        mem_wdata <= wdata;
                        mem_wr_n  <= 1'b0;
                        state     <= StWrite;
                     end else begin
                        mem_rd  <= 1'b1;
                        waitCnt <= 4'd0;
                        state   <= StRead;
                     end
                  end
               end
            end
            StRead: begin
               if (waitCnt == WaitLast) begin
                  mem_rd <= 1'b0;
                  if (weQ) begin
                     mem_wdata <= mergedWord;
                     mem_wr_n  <= 1'b0;
                     state     <= StWrite;
                  end else begin
                     rdata <= loadWord;
                     done  <= 1'b1;
                     state <= StDone;
                  end
               end else begin
                  waitCnt <= waitCnt + 4'd1;
               end
            end
            StWrite: begin
               mem_wr_n <= 1'b1;
               done     <= 1'b1;
               state    <= StDone;
            end
            StDone: begin
               busy  <= 1'b0;
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit against a byte-array memory model.
module tb_mem_access_unit;

   localparam int unsigned RW = 1;
`ifdef MAU_ALIGN_CHECK_EN
   localparam bit AlignCheck = 1'b1;
`else
   localparam bit AlignCheck = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        Reset = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  size = 2'b00;
   logic        sign_ext = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic        busy, done, misalign, mem_rd, mem_wr_n;
   logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

   mem_access_unit #(.ADDR_W(32), .READ_WAIT(RW)) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .req       (req),
      .we        (we),
      .size      (size),
      .sign_ext  (sign_ext),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .rdata     (rdata),
      .misalign  (misalign),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rd    (mem_rd),
      .mem_wr_n  (mem_wr_n),
      .mem_rdata (mem_rdata)
   );

   always #5 CLK = ~CLK;

   // Physical memory seen by the DUT (16 words, address bits [5:2]).
   logic [31:0] mem [16];
   assign mem_rdata = mem[mem_addr[5:2]];
   always @(negedge CLK) if (!mem_wr_n) mem[mem_addr[5:2]] <= mem_wdata;

   // Reference memory as big-endian bytes.
   logic [7:0] refMem [64];

   int posCount = 0;
   always @(posedge CLK) posCount <= posCount + 1;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      int          start;
      int          lat;
      bit          misal;
      bit          chkRd;
      logic [31:0] rdata;
      int          rdCyc;
      int          wrCyc;
      logic [31:0] maddr;
   } expT;

   expT expQ[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: actual %08h required %08h", name, act, exp);
      end
   endtask

   task automatic modelOp(input bit w, input logic [1:0] sz, input bit se,
                          input logic [31:0] a, input logic [31:0] wd, output expT e);
      int n;
      int base;
      logic [31:0] v;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      e.misal = AlignCheck && ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00));
      e.maddr = {a[31:2], 2'b00};
      e.rdata = 32'd0;
      if (e.misal) begin
         e.lat = 1; e.rdCyc = 0; e.wrCyc = 0; e.chkRd = 1'b1;
         return;
      end
      base = int'(a[5:0]) & ~(n - 1);
      if (w) begin
         for (int i = 0; i < n; i++) refMem[base + i] = 8'(wd >> (8 * (n - 1 - i)));
         e.lat   = (n == 4) ? 2 : 3 + RW;
         e.rdCyc = (n == 4) ? 0 : RW + 1;
         e.wrCyc = 1;
         e.chkRd = 1'b0;
      end else begin
         v = 32'd0;
         for (int i = 0; i < n; i++) v = (v << 8) | 32'(refMem[base + i]);
         if (se && n < 4 && v[8 * n - 1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
         e.rdata = v;
         e.lat   = 2 + RW;
         e.rdCyc = RW + 1;
         e.wrCyc = 0;
         e.chkRd = 1'b1;
      end
   endtask

   // Monitor: pops one expectation per done pulse.
   int rdCnt = 0;
   int wrCnt = 0;
   always @(negedge CLK) begin
      expT e;
      if (!busy) begin
         rdCnt = 0;
         wrCnt = 0;
      end
      if (mem_rd) rdCnt++;
      if (!mem_wr_n) wrCnt++;
      if (Reset && done) begin
         if (expQ.size() == 0) begin
            check("spurious_done", done, 1'b0);
         end else begin
            e = expQ.pop_front();
            check("latency", 32'(posCount - e.start), 32'(e.lat));
            check("misalign", misalign, e.misal);
            check("busy_in_done", busy, 1'b1);
            check("mem_rd_cycles", 32'(rdCnt), 32'(e.rdCyc));
            check("mem_wr_cycles", 32'(wrCnt), 32'(e.wrCyc));
            if (e.chkRd) check("rdata", rdata, e.rdata);
            if (!e.misal) check("mem_addr", mem_addr, e.maddr);
         end
         rdCnt = 0;
         wrCnt = 0;
      end
   end

   task automatic doOp(input bit w, input logic [1:0] sz, input bit se,
                       input logic [31:0] a, input logic [31:0] wd);
      expT e;
      bit  seen;
      @(negedge CLK);
      modelOp(w, sz, se, a, wd, e);
      e.start = posCount;
      expQ.push_back(e);
      req = 1'b1; we = w; size = sz; sign_ext = se; addr = a; wdata = wd;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge CLK);
         seen = done;
         // Junk requests while busy must be ignored.
         req = 1'($urandom); we = 1'($urandom); size = 2'($urandom);
         sign_ext = 1'($urandom); addr = $urandom; wdata = $urandom;
      end
      check("done_seen", seen, 1'b1);
      @(negedge CLK);
      req = 1'b0;
      check("busy_after_done", busy, 1'b0);
   endtask

   task automatic resetAbortTest();
      bit ok;
      @(negedge CLK);
      req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h1A; wdata = $urandom;
      @(negedge CLK);
      req = 1'b0;
      check("rd_before_abort", mem_rd, 1'b1);
      Reset = 1'b0;
      @(negedge CLK);
      Reset = 1'b1;
      ok = 1'b1;
      repeat (6) begin
         @(negedge CLK);
         if (done || !mem_wr_n || mem_rd || busy) ok = 1'b0;
      end
      check("reset_abort_quiet", ok, 1'b1);
   endtask

   initial begin
      logic [31:0] w;
      for (int i = 0; i < 16; i++) begin
         w = $urandom;
         mem[i] = w;
         for (int j = 0; j < 4; j++) refMem[4 * i + j] = 8'(w >> (24 - 8 * j));
      end

      Reset = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_misalign", misalign, 1'b0);
      check("rst_mem_rd", mem_rd, 1'b0);
      check("rst_mem_wr_n", mem_wr_n, 1'b1);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      Reset = 1'b1;

      doOp(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
      doOp(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      check("word_load_const", rdata, 32'h11223344);
      doOp(1'b1, 2'b00, 1'b0, 32'h12, 32'h5A5A5AAB);
      check("byte_store_word", mem[4], 32'h1122AB44);
      doOp(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
      check("byte_load_sext", rdata, 32'hFFFFFFAB);
      doOp(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
      check("byte_load_zext", rdata, 32'h000000AB);
      doOp(1'b1, 2'b01, 1'b0, 32'h12, 32'h7777BEEF);
      check("half_store_word", mem[4], 32'h1122BEEF);
      doOp(1'b1, 2'b01, 1'b0, 32'h10, 32'h00008001);
      doOp(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
      check("half_load_sext", rdata, 32'hFFFF8001);
      doOp(1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
      doOp(1'b1, 2'b11, 1'b0, 32'h21, 32'hCAFEF00D);
      doOp(1'b1, 2'b01, 1'b0, 32'h23, 32'h0000D00D);
      resetAbortTest();

      for (int n = 0; n < 200; n++) begin
         doOp(1'($urandom), 2'($urandom), 1'($urandom),
              {26'($urandom), 6'($urandom)}, $urandom);
      end

      repeat (2) @(negedge CLK);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("mem_word_%0d", i), mem[i],
               {refMem[4 * i], refMem[4 * i + 1], refMem[4 * i + 2], refMem[4 * i + 3]});
      end
      check("queue_drained", 32'(expQ.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
